// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 device-to-host frame receiver with stb/ack word output
// Checks start/parity/stop, times out stalled frames, and flags overrun on the next delivered word.
module ps2_keyboard_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] output_ps2,
  output logic        output_ps2_stb,
  input  logic        output_ps2_ack,
  output logic        frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, STOP} state_e;

  state_e        state_q, state_d;
  logic          clk_meta_q, clk_sync_q, clk_hist_q;
  logic          data_meta_q, data_sync_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [8:0]    shift_q, shift_d;
  logic [8:0]    word_q, word_d;
  logic          stb_q, stb_d;
  logic          overrun_q, overrun_d;
  logic          err_q, err_d;

  logic fall;
  logic timeout;

  assign fall    = clk_hist_q & ~clk_sync_q;
  assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_hist_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      stb_q       <= 1'b0;
      overrun_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_hist_q  <= clk_sync_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      stb_q       <= stb_d;
      overrun_q   <= overrun_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    word_d    = word_q;
    stb_d     = stb_q & ~output_ps2_ack;
    overrun_d = overrun_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) begin
          if (!data_sync_q) begin
            state_d   = RECEIVE;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RECEIVE: begin
        if (fall) begin
          shift_d   = {data_sync_q, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          timer_d   = '0;
          if (bit_cnt_q == 4'd8) state_d = STOP;
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          timer_d = '0;
          if (data_sync_q && (^shift_q)) begin
            // A held word that is not being taken this cycle keeps priority.
            if (!stb_q || output_ps2_ack) begin
              word_d    = {overrun_q, shift_q[7:0]};
              stb_d     = 1'b1;
              overrun_d = 1'b0;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign output_ps2     = {23'b0, word_q};
  assign output_ps2_stb = stb_q;
  assign frame_error    = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] out;
  logic        stb;
  logic        ack = 1'b1;
  logic        ferr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int err_cyc = -1;
  int stb_rise_cyc = -1;
  int last_fall_cyc = 0;
  logic [31:0] last_word = '0;
  logic stb_prev = 1'b0;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .output_ps2(out), .output_ps2_stb(stb), .output_ps2_ack(ack),
    .frame_error(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (stb && !stb_prev) stb_rise_cyc = cyc;
    if (stb) begin
      stb_cnt = stb_cnt + 1;
      last_word = out;
    end
    if (ferr) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    stb_prev = stb;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    idle(4);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    idle(10);
    ps2_clk = 1'b1;
    idle(6);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stp);
    ps2_data = 1'b1;
    idle(10);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    checks++;
    if (out !== 32'h0 || stb !== 1'b0 || ferr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out=%h stb=%b ferr=%b expected 0/0/0", out, stb, ferr);
    end
    rst = 1'b1;
    idle(5);
  endtask

  task automatic test_valid_frame();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++;
    if (last_word !== 32'h0000001C) begin
      failures++; $display("FAIL valid_word got %h expected 0000001c", last_word);
    end
    checks++;
    if (stb_cnt - s0 !== 1) begin
      failures++; $display("FAIL valid_stb_cycles got %0d expected 1", stb_cnt - s0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      failures++; $display("FAIL valid_no_error got %0d expected 0", err_cnt - e0);
    end
    checks++;
    if (stb_rise_cyc !== last_fall_cyc + 3) begin
      failures++; $display("FAIL stb_latency got %0d expected %0d", stb_rise_cyc, last_fall_cyc + 3);
    end
  endtask

  task automatic test_parity_error();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++; $display("FAIL parity_error_pulses got %0d expected 1", err_cnt - e0);
    end
    checks++;
    if (stb_cnt - s0 !== 0) begin
      failures++; $display("FAIL parity_no_stb got %0d expected 0", stb_cnt - s0);
    end
    send_frame(8'hF0, 1'b1, 1'b1);
    checks++;
    if (last_word !== 32'h000000F0) begin
      failures++; $display("FAIL after_parity_word got %h expected 000000f0", last_word);
    end
  endtask

  task automatic test_stop_and_idle_error();
    int s0, e0;
    s0 = stb_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++;
    if (err_cnt - e0 !== 1 || stb_cnt - s0 !== 0) begin
      failures++; $display("FAIL stop_error errs=%0d stbs=%0d expected 1/0", err_cnt - e0, stb_cnt - s0);
    end
    e0 = err_cnt;
    ps2_bit(1'b1);
    idle(10);
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++; $display("FAIL idle_high_start got %0d expected 1", err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    idle(T + 20);
    checks++;
    if (err_cnt - e0 !== 1) begin
      failures++; $display("FAIL timeout_pulses got %0d expected 1", err_cnt - e0);
    end
    checks++;
    if (err_cyc !== last_fall_cyc + 3 + T) begin
      failures++; $display("FAIL timeout_cycle got %0d expected %0d", err_cyc, last_fall_cyc + 3 + T);
    end
    send_frame(8'hF0, 1'b1, 1'b1);
    checks++;
    if (last_word !== 32'h000000F0) begin
      failures++; $display("FAIL after_timeout_word got %h expected 000000f0", last_word);
    end
  endtask

  task automatic test_overrun();
    ack = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    checks++;
    if (out !== 32'h0000001C || stb !== 1'b1) begin
      failures++; $display("FAIL overrun_hold out=%h stb=%b expected 0000001c/1", out, stb);
    end
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    checks++;
    if (stb !== 1'b0) begin
      failures++; $display("FAIL ack_drops_stb got %b expected 0", stb);
    end
    send_frame(8'h5A, 1'b1, 1'b1);
    checks++;
    if (out !== 32'h0000015A) begin
      failures++; $display("FAIL overrun_flag got %h expected 0000015a", out);
    end
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++;
    if (out !== 32'h0000001C || stb !== 1'b1) begin
      failures++; $display("FAIL overrun_cleared out=%h stb=%b expected 0000001c/1", out, stb);
    end
    ack = 1'b1;
    idle(3);
  endtask

  task automatic test_reset_mid_frame();
    int s0, e0;
    ack = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stb !== 1'b0 || ferr !== 1'b0 || out !== 32'h0) begin
      failures++; $display("FAIL reset_mid_frame stb=%b ferr=%b out=%h expected 0/0/0", stb, ferr, out);
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    idle(5);
    rst = 1'b1;
    ack = 1'b1;
    idle(5);
    s0 = stb_cnt; e0 = err_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    checks++;
    if (last_word !== 32'h000000E0 || stb_cnt - s0 !== 1) begin
      failures++; $display("FAIL after_reset_word got %h stbs=%0d expected 000000e0/1", last_word, stb_cnt - s0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      failures++; $display("FAIL after_reset_no_error got %0d expected 0", err_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_stop_and_idle_error();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Receives device-to-host frames from a PS/2 keyboard on the Atlys board and delivers each valid scan-code byte as a 32-bit word on a stb/ack stream. It sits directly upstream of the keyboard application's ps2 input stream (input_ps2 / input_ps2_stb / input_ps2_ack). It synchronises the raw PS/2 pins, checks start, parity and stop bits, and times out stalled frames. Bad frames are discarded and flagged.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed between consecutive ps2_clk falling edges inside a frame (1 ms at 100 MHz).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
ps2_clk  input  1  raw PS/2 clock pin, asynchronous; idles high
ps2_data  input  1  raw PS/2 data pin, asynchronous; idles high
output_ps2  output  32  [7:0] scan code, [8] overrun flag, [31:9] zero
output_ps2_stb  output  1  output word valid
output_ps2_ack  input  1  consumer accepts word
frame_error  output  1  one-cycle pulse per discarded frame

Behaviour:
- Reset (rst=0, async): output_ps2=0, output_ps2_stb=0, frame_error=0, FSM=IDLE, bit counter=0, timer=0, overrun_pending=0, sync flops=1. A frame in progress is lost.
- Synchronisation: two-flop synchronisers on ps2_clk and ps2_data, plus one history flop on the synced clock. A falling edge is history=1 and synced=0; data is sampled from synced ps2_data in the same cycle.
- FSM states: IDLE, RECEIVE, STOP.
  - IDLE, falling edge, data=0 -> RECEIVE; bit_count=0, timer=0.
  - IDLE, falling edge, data=1 -> frame_error pulse; stay IDLE.
  - RECEIVE, each falling edge: shift data into shift[8:0], LSB first (8 data bits then parity); bit_count++. The 9th edge -> STOP.
  - STOP, falling edge: frame is good if data=1 and XOR(shift[8:0])=1 (odd parity). Good -> deliver. Bad -> frame_error pulse. Either way -> IDLE.
- Timeout: in RECEIVE/STOP, timer increments every cycle and clears on each falling edge. When timer reaches TIMEOUT_CYCLES -> IDLE, frame_error pulse, partial frame discarded. The timer saturates and does not wrap.
- Deliver, registered on the STOP falling-edge cycle:
  - if stb=0, or stb=1 and ack=1 in the same cycle: output_ps2 = {23'b0, overrun_pending, byte}; stb=1; overrun_pending cleared.
  - if stb=1 and ack=0: new byte dropped, overrun_pending set; held word unchanged.
- Handshake:
  - Transfer occurs on a clk edge where stb=1 and ack=1. stb drops the next cycle unless a new delivery coincides.
  - output_ps2 is stable while stb=1. ack while stb=0 is ignored.
- Latency: stb rises 3 clk edges after the first clk edge that samples ps2_clk low for the stop bit.
- frame_error and delivery never occur in the same cycle.
- Simultaneous timeout and falling edge in the same cycle: the falling edge wins; timer clears.

Test Plan:
1. Frame 0x1C, parity 0, stop 1, ack tied high -> output_ps2=0x0000001C, stb high exactly 1 cycle, frame_error never asserted.
2. Frame 0x1C with parity 1 -> no stb, frame_error high exactly 1 cycle. Follow with valid 0xF0 (parity 1) -> output 0x000000F0.
3. Frame 0x5A (parity 1) with stop bit 0 -> frame_error pulse, no stb. Also: ps2_data=1 at a falling edge in IDLE -> frame_error pulse, FSM stays IDLE.
4. Start bit plus 4 data bits, then ps2_clk held high -> frame_error exactly TIMEOUT_CYCLES cycles after the last falling edge. Next full 0xF0 frame -> 0x000000F0.
5. ack held low; send 0x1C then 0x32 -> output stays 0x0000001C. Pulse ack -> stb drops. Send 0x5A -> 0x0000015A (overrun bit set). Send 0x1C -> 0x0000001C (bit cleared).
6. Assert rst=0 after 5 data bits -> stb=0 and frame_error=0 immediately. Release, send 0xE0 (parity 0) -> 0x000000E0, no frame_error.
